// File: rtl/shift_right_seq.sv
// Multi-cycle logarithmic right shifter (logical/arithmetic) with valid/ready on both sides.
// One shifter stage per clock; the result is held in R until the consumer accepts it.
module shift_right_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             arith,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] R
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] LAST_STAGE = SHW'(SHW - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [SHW-1:0]   shamt_q, shamt_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic             fill_q, fill_d;
    logic             out_valid_q, out_valid_d;

    logic [WIDTH-1:0] stage_s;
    logic             oor_s;
    logic             fill_in_s;

    // One logarithmic stage: shift right by 2^idx, filling vacated bits with f.
    function automatic logic [WIDTH-1:0] shift_stage(input logic [WIDTH-1:0] d,
                                                     input logic             f,
                                                     input logic [SHW-1:0]   idx);
        logic [WIDTH-1:0] fmask;
        fmask = ~({WIDTH{1'b1}} >> (WIDTH'(1) << idx));
        return (d >> (WIDTH'(1) << idx)) | (f ? fmask : {WIDTH{1'b0}});
    endfunction

    assign stage_s   = shamt_q[cnt_q] ? shift_stage(data_q, fill_q, cnt_q) : data_q;
    assign oor_s     = |B[WIDTH-1:SHW];
    assign fill_in_s = arith & A[WIDTH-1];

    // Next-state and datapath update for the IDLE/BUSY/DONE sequence.
    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        r_d         = r_q;
        shamt_d     = shamt_q;
        cnt_d       = cnt_q;
        fill_d      = fill_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    fill_d  = fill_in_s;
                    cnt_d   = {SHW{1'b0}};
                    state_d = BUSY;
                    // Out-of-range amounts collapse to an all-fill word shifted by zero.
                    if (oor_s) begin
                        data_d  = {WIDTH{fill_in_s}};
                        shamt_d = {SHW{1'b0}};
                    end else begin
                        data_d  = A;
                        shamt_d = B[SHW-1:0];
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                data_d = stage_s;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST_STAGE) begin
                    r_d         = stage_s;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    state_d = BUSY;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            data_q      <= {WIDTH{1'b0}};
            r_q         <= {WIDTH{1'b0}};
            shamt_q     <= {SHW{1'b0}};
            cnt_q       <= {SHW{1'b0}};
            fill_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            r_q         <= r_d;
            shamt_q     <= shamt_d;
            cnt_q       <= cnt_d;
            fill_q      <= fill_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign R         = r_q;

endmodule

// File: tb/tb_shift_right_seq.sv
// Scoreboard bench for shift_right_seq: expected results are queued at issue time
// from an independent shift model and popped when out_valid appears.
module tb_shift_right_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic        arith;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] R;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    shift_right_seq #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .A        (A),
        .B        (B),
        .arith    (arith),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .R        (R)
    );

    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic ar);
        logic signed [31:0] sa;
        sa = a;
        if (b >= 32'd32) begin
            if (ar && a[31]) return 32'hFFFF_FFFF;
            return 32'h0000_0000;
        end
        if (ar) return sa >>> b[4:0];
        return a >> b[4:0];
    endfunction

    // Wait for in_ready, present one operand set for the accept edge, optionally queue its result.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic ar,
                         input bit push);
        int w;
        w = 0;
        while (!in_ready && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        n_tests++;
        if (!in_ready) begin
            n_fail++;
            $display("FAIL issue_ready: in_ready=%0b required 1", in_ready);
        end
        if (push) exp_q.push_back(model(a, b, ar));
        A = a; B = b; arith = ar; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Count accept-relative edges until out_valid; -1 on timeout.
    task automatic wait_out(output int lat);
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        A = 32'h0; B = 32'h0; arith = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || R !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: out_valid=%0b R=%h required 0 and 00000000", out_valid, R);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: in_ready=%0b out_valid=%0b required 1 and 0", in_ready, out_valid);
        end
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        ar;
    } vec_t;

    task automatic test_shifts();
        vec_t v[14];
        int lat;
        logic [31:0] e;
        v[0]  = '{32'h8000_0000, 32'd4,  1'b0};
        v[1]  = '{32'h8000_0000, 32'd4,  1'b1};
        v[2]  = '{32'h8000_0000, 32'd31, 1'b1};
        v[3]  = '{32'h8000_0000, 32'd31, 1'b0};
        v[4]  = '{32'h1234_5678, 32'd0,  1'b0};
        v[5]  = '{32'h1234_5678, 32'd16, 1'b0};
        v[6]  = '{32'h8000_0001, 32'd32, 1'b0};
        v[7]  = '{32'h8000_0001, 32'd32, 1'b1};
        v[8]  = '{32'h8000_0001, 32'hFFFF_FFFF, 1'b0};
        v[9]  = '{32'h8000_0001, 32'hFFFF_FFFF, 1'b1};
        v[10] = '{32'h7FFF_FFFF, 32'd32, 1'b1};
        v[11] = '{32'h7FFF_FFFF, 32'd5,  1'b1};
        v[12] = '{32'hF0F0_1234, 32'h21, 1'b1};
        v[13] = '{32'hC3A5_96E1, 32'd13, 1'b1};
        for (int i = 0; i < 14; i++) begin
            issue(v[i].a, v[i].b, v[i].ar, 1'b1);
            wait_out(lat);
            n_tests++;
            if (lat != 5) begin
                n_fail++;
                $display("FAIL shift_latency[%0d]: latency=%0d required 5", i, lat);
            end
            e = exp_q.pop_front();
            n_tests++;
            if (R !== e) begin
                n_fail++;
                $display("FAIL shift_result[%0d]: R=%h required %h", i, R, e);
            end
            release_out();
            n_tests++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL shift_release[%0d]: out_valid=%0b in_ready=%0b required 0 and 1", i, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        bit seen;
        logic [31:0] e;
        issue(32'h1234_5678, 32'd8, 1'b0, 1'b1);
        A = 32'hDEAD_BEEF; B = 32'd1; arith = 1'b1; in_valid = 1'b1;
        wait_out(lat);
        e = exp_q.pop_front();
        n_tests++;
        if (lat != 5 || R !== e) begin
            n_fail++;
            $display("FAIL bp_first: latency=%0d R=%h required 5 and %h", lat, R, e);
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            n_tests++;
            if (out_valid !== 1'b1 || R !== e || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: out_valid=%0b R=%h in_ready=%0b required 1 %h 0", i, out_valid, R, in_ready, e);
            end
        end
        in_valid = 1'b0;
        release_out();
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || R !== e) begin
            n_fail++;
            $display("FAIL bp_release: out_valid=%0b in_ready=%0b R=%h required 0 1 %h", out_valid, in_ready, R, e);
        end
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (out_valid || !in_ready) seen = 1'b1;
        end
        n_tests++;
        if (seen) begin
            n_fail++;
            $display("FAIL bp_dropped: dropped operands started work, required idle");
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        bit seen;
        logic [31:0] e;
        issue(32'h8000_0000, 32'd4, 1'b1, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        #1 rst_n = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || R !== 32'h0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_async: out_valid=%0b R=%h in_ready=%0b required 0 00000000 1", out_valid, R, in_ready);
        end
        #1 rst_n = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (out_valid || !in_ready) seen = 1'b1;
        end
        n_tests++;
        if (seen) begin
            n_fail++;
            $display("FAIL midreset_abandon: activity after abandoned operation, required idle");
        end
        issue(32'h8000_0000, 32'd4, 1'b0, 1'b1);
        wait_out(lat);
        e = exp_q.pop_front();
        n_tests++;
        if (lat != 5 || R !== e) begin
            n_fail++;
            $display("FAIL midreset_retry: latency=%0d R=%h required 5 and %h", lat, R, e);
        end
        release_out();
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [31:0] a, b, e;
        logic ar;
        for (int i = 0; i < 12; i++) begin
            a  = $urandom;
            b  = (i % 4 == 3) ? $urandom : 32'($urandom_range(0, 40));
            ar = 1'($urandom_range(0, 1));
            issue(a, b, ar, 1'b1);
            wait_out(lat);
            e = exp_q.pop_front();
            n_tests++;
            if (lat != 5 || R !== e) begin
                n_fail++;
                $display("FAIL b2b[%0d]: A=%h B=%h arith=%0b latency=%0d R=%h required 5 and %h", i, a, b, ar, lat, R, e);
            end
            release_out();
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: %0d entries left, required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_shifts();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
